steamer_sram_responder: RTL and testbench

- Bus responder (slave) for the STEAMER16 16-bit bus. It receives requests from the CPU or any other bus initiator.
- Converts each request into one access on the board's external asynchronous 16-bit SRAM, with an address setup cycle, programmable strobe width, and a hold/turnaround cycle.
- Returns a single-cycle ack_o, plus registered read data, to the initiator.

---
 rtl/steamer_sram_responder.sv | 134 +++++++++++++
 tb/tb_steamer_sram_responder.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/steamer_sram_responder.sv
// STEAMER16 bus responder driving an external asynchronous 16-bit SRAM.
// Optional write protection above ROM_BASE: compile with STEAMER_SRAM_ROMPROT_EN.
//
// state  | meaning
// IDLE   | waiting for a request; the only state that samples bus inputs
// SETUP  | chip enable, address and byte lanes asserted one cycle before the strobe
// STROBE | oe_n or we_n low for WAIT_STATES cycles
// HOLD   | strobe released, CE and write data held; ack returned if cyc_i is still high
module steamer_sram_responder #(
  parameter int unsigned WAIT_STATES = 2,
  parameter logic [14:0] ROM_BASE    = 15'h7C00
) (
  input  logic        clk_i,
  input  logic        res_ni,
  input  logic [14:0] adr_i,
  input  logic        we_i,
  input  logic        cyc_i,
  input  logic [1:0]  stb_i,
  input  logic [15:0] dat_i,
  output logic [15:0] dat_o,
  output logic        ack_o,
  output logic [14:0] sram_adr_o,
  input  logic [15:0] sram_dq_i,
  output logic [15:0] sram_dq_o,
  output logic        sram_dq_oe_o,
  output logic        sram_ce_n_o,
  output logic        sram_oe_n_o,
  output logic        sram_we_n_o,
  output logic        sram_ub_n_o,
  output logic        sram_lb_n_o
);

  localparam logic [3:0] WS_CNT = WAIT_STATES[3:0];

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [14:0] adr_q;
  logic        we_q;
  logic [1:0]  stb_q;
  logic [15:0] wdat_q;
  logic        null_q;
  logic [15:0] rdat_q;
  logic        capture;
  logic        active;
  logic        wr_prot;
  logic        wr_ok;

`ifdef STEAMER_SRAM_ROMPROT_EN
  assign wr_prot = (adr_q >= ROM_BASE);
`else
  logic rom_base_unused;
  assign rom_base_unused = ^ROM_BASE;
  assign wr_prot = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge res_ni) begin
    if (!res_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (cyc_i) state_d = (stb_i == 2'b00) ? HOLD : SETUP;
      end
      SETUP: begin
        cnt_d   = WS_CNT;
        state_d = STROBE;
      end
      STROBE: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          capture = ~we_q;
          state_d = HOLD;
        end
      end
      HOLD: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Request registers load only in IDLE so mid-access bus changes are ignored.
  always_ff @(posedge clk_i or negedge res_ni) begin
    if (!res_ni) begin
      adr_q  <= '0;
      we_q   <= 1'b0;
      stb_q  <= 2'b00;
      wdat_q <= '0;
      null_q <= 1'b0;
    end else if (state_q == IDLE && cyc_i) begin
      null_q <= (stb_i == 2'b00);
      if (stb_i != 2'b00) begin
        adr_q  <= adr_i;
        we_q   <= we_i;
        stb_q  <= stb_i;
        wdat_q <= dat_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge res_ni) begin
    if (!res_ni) rdat_q <= '0;
    else if (capture) rdat_q <= sram_dq_i;
  end

  // A null request passes through HOLD without touching the SRAM.
  assign active = (state_q == SETUP) || (state_q == STROBE) ||
                  ((state_q == HOLD) && !null_q);
  assign wr_ok  = we_q && !wr_prot;

  assign sram_adr_o   = adr_q;
  assign sram_dq_o    = wdat_q;
  assign sram_ce_n_o  = ~active;
  assign sram_ub_n_o  = ~(active && stb_q[1]);
  assign sram_lb_n_o  = ~(active && stb_q[0]);
  assign sram_oe_n_o  = ~((state_q == STROBE) && !we_q);
  assign sram_we_n_o  = ~((state_q == STROBE) && wr_ok);
  assign sram_dq_oe_o = active && wr_ok;
  assign ack_o        = (state_q == HOLD) && cyc_i;
  assign dat_o        = rdat_q;

endmodule

// File: tb/tb_steamer_sram_responder.sv
// Randomized bench for steamer_sram_responder against a word-level SRAM reference model.
module tb_steamer_sram_responder;
  localparam int unsigned WS       = 2;
  localparam logic [14:0] ROM_BASE = 15'h7C00;

  logic        clk_i = 1'b0;
  logic        res_ni;
  logic [14:0] adr_i;
  logic        we_i;
  logic        cyc_i;
  logic [1:0]  stb_i;
  logic [15:0] dat_i;
  logic [15:0] dat_o;
  logic        ack_o;
  logic [14:0] sram_adr_o;
  logic [15:0] sram_dq_i;
  logic [15:0] sram_dq_o;
  logic        sram_dq_oe_o;
  logic        sram_ce_n_o;
  logic        sram_oe_n_o;
  logic        sram_we_n_o;
  logic        sram_ub_n_o;
  logic        sram_lb_n_o;

  int checks = 0;
  int errors = 0;

  logic [15:0] sram_mem [0:32767];
  logic [15:0] ref_mem  [0:32767];
  logic [15:0] ref_dat  = 16'h0000;
  logic        prev_ack = 1'b0;

  always #5 clk_i = ~clk_i;

  steamer_sram_responder #(.WAIT_STATES(WS), .ROM_BASE(ROM_BASE)) dut (
    .clk_i(clk_i), .res_ni(res_ni), .adr_i(adr_i), .we_i(we_i), .cyc_i(cyc_i),
    .stb_i(stb_i), .dat_i(dat_i), .dat_o(dat_o), .ack_o(ack_o),
    .sram_adr_o(sram_adr_o), .sram_dq_i(sram_dq_i), .sram_dq_o(sram_dq_o),
    .sram_dq_oe_o(sram_dq_oe_o), .sram_ce_n_o(sram_ce_n_o), .sram_oe_n_o(sram_oe_n_o),
    .sram_we_n_o(sram_we_n_o), .sram_ub_n_o(sram_ub_n_o), .sram_lb_n_o(sram_lb_n_o)
  );

  // Pin-level SRAM: reads drive the bus while CE and OE are low, writes land per lane.
  assign sram_dq_i = (!sram_ce_n_o && !sram_oe_n_o) ? sram_mem[sram_adr_o] : 16'h0BAD;

  always @(posedge clk_i) begin
    if (!sram_ce_n_o && !sram_we_n_o && sram_dq_oe_o) begin
      if (!sram_ub_n_o) sram_mem[sram_adr_o][15:8] <= sram_dq_o[15:8];
      if (!sram_lb_n_o) sram_mem[sram_adr_o][7:0]  <= sram_dq_o[7:0];
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  always @(negedge clk_i) begin
    if (res_ni && ack_o) begin
      check("ack_with_cyc", {31'd0, cyc_i}, 32'd1);
      check("ack_single", {31'd0, prev_ack}, 32'd0);
    end
    prev_ack <= ack_o;
  end

  task automatic scramble();
    adr_i = 15'($urandom);
    we_i  = 1'($urandom);
    stb_i = 2'($urandom);
    dat_i = 16'($urandom);
  endtask

  // Entered just after a rising edge; request presented in that cycle (cycle 0).
  task automatic do_access(input logic [14:0] a, input logic w, input logic [1:0] s,
                           input logic [15:0] d, input bit drop);
    bit is_null, prot, wr_eff;
    int ack_at, ack_n, ce_cnt, dqoe_cnt, oe_cnt, we_cnt, first_oe, first_we, last_k;
    is_null = (s == 2'b00);
    prot = 1'b0;
`ifdef STEAMER_SRAM_ROMPROT_EN
    prot = w && (a >= ROM_BASE);
`endif
    wr_eff = w && !is_null && !prot;
    if (wr_eff) begin
      if (s[1]) ref_mem[a][15:8] = d[15:8];
      if (s[0]) ref_mem[a][7:0]  = d[7:0];
    end else if (!w && !is_null) begin
      ref_dat = ref_mem[a];
    end
    ack_at = -1; ack_n = 0; ce_cnt = 0; dqoe_cnt = 0; oe_cnt = 0; we_cnt = 0;
    first_oe = -1; first_we = -1;
    last_k = drop ? int'(WS) + 3 : int'(WS) + 8;
    adr_i = a; we_i = w; stb_i = s; dat_i = d; cyc_i = 1'b1;
    for (int k = 0; k <= last_k; k++) begin
      @(negedge clk_i);
      if (ack_o) begin ack_n++; if (ack_at < 0) ack_at = k; end
      if (!sram_ce_n_o) ce_cnt++;
      if (sram_dq_oe_o) dqoe_cnt++;
      if (!sram_oe_n_o) begin oe_cnt++; if (first_oe < 0) first_oe = k; end
      if (!sram_we_n_o) begin we_cnt++; if (first_we < 0) first_we = k; end
      if (k == 2 && !is_null) begin
        check("sram_adr", {17'd0, sram_adr_o}, {17'd0, a});
        check("ub_n", {31'd0, sram_ub_n_o}, {31'd0, ~s[1]});
        check("lb_n", {31'd0, sram_lb_n_o}, {31'd0, ~s[0]});
        if (wr_eff) check("dq_out", {16'd0, sram_dq_o}, {16'd0, d});
      end
      if (ack_o && !w && !is_null) check("rdata_at_ack", {16'd0, dat_o}, {16'd0, ref_dat});
      @(posedge clk_i); #1;
      if (ack_at >= 0) break;
      if (drop && k == 1) cyc_i = 1'b0;
      scramble();
    end
    cyc_i = 1'b0;
    scramble();
    if (drop) check("drop_no_ack", ack_n, 0);
    else begin
      check("ack_count", ack_n, 1);
      check("latency", ack_at, is_null ? 1 : int'(WS) + 2);
    end
    check("ce_cycles", ce_cnt, is_null ? 0 : int'(WS) + 2);
    check("oe_cycles", oe_cnt, (!w && !is_null) ? int'(WS) : 0);
    check("we_cycles", we_cnt, wr_eff ? int'(WS) : 0);
    check("dq_oe_cycles", dqoe_cnt, wr_eff ? int'(WS) + 2 : 0);
    if (oe_cnt > 0) check("oe_start", first_oe, 2);
    if (we_cnt > 0) check("we_start", first_we, 2);
    check("dat_o_held", {16'd0, dat_o}, {16'd0, ref_dat});
    if (!is_null) check("mem_word", {16'd0, sram_mem[a]}, {16'd0, ref_mem[a]});
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_i); #1;
    end
  endtask

  initial begin
    logic [15:0] v;
    logic [14:0] a;
    for (int i = 0; i < 32768; i++) begin
      v = 16'($urandom);
      sram_mem[i] = v;
      ref_mem[i]  = v;
    end
    sram_mem[16] = 16'hA55A;
    ref_mem[16]  = 16'hA55A;
    res_ni = 1'b0; cyc_i = 1'b0; adr_i = '0; we_i = 1'b0; stb_i = 2'b00; dat_i = '0;
    #1;
    check("rst_ce_n", {31'd0, sram_ce_n_o}, 32'd1);
    check("rst_oe_n", {31'd0, sram_oe_n_o}, 32'd1);
    check("rst_we_n", {31'd0, sram_we_n_o}, 32'd1);
    check("rst_ublb", {30'd0, sram_ub_n_o, sram_lb_n_o}, 32'd3);
    check("rst_dq_oe", {31'd0, sram_dq_oe_o}, 32'd0);
    check("rst_ack", {31'd0, ack_o}, 32'd0);
    check("rst_dat_o", {16'd0, dat_o}, 32'd0);
    check("rst_adr_dq", {sram_adr_o, 1'b0, sram_dq_o}, 32'd0);
    idle_cycles(2);
    res_ni = 1'b1;
    idle_cycles(2);

    do_access(15'h0010, 1'b0, 2'b11, 16'h0000, 1'b0);
    check("read_a55a", {16'd0, dat_o}, 32'h0000A55A);
    idle_cycles(1);
    do_access(15'h0020, 1'b1, 2'b10, 16'h1234, 1'b0);
    check("byte_hi", {24'd0, sram_mem[15'h0020][15:8]}, 32'h12);
    do_access(15'h0030, 1'b1, 2'b11, 16'hBEEF, 1'b0);
    do_access(15'h0030, 1'b0, 2'b11, 16'h0000, 1'b0);
    check("b2b_read", {16'd0, dat_o}, 32'h0000BEEF);
    do_access(15'h0044, 1'b0, 2'b00, 16'h0000, 1'b0);
    do_access(15'h0040, 1'b1, 2'b11, 16'h5678, 1'b1);
    do_access(15'h0041, 1'b0, 2'b11, 16'h0000, 1'b1);
    do_access(15'h0040, 1'b0, 2'b01, 16'h0000, 1'b0);

    // Reset asserted mid-strobe of a write; outputs must drop without a clock edge.
    adr_i = 15'h0050; we_i = 1'b1; stb_i = 2'b11; dat_i = 16'hC0DE; cyc_i = 1'b1;
    idle_cycles(2);
    #2;
    check("pre_rst_we_low", {31'd0, sram_we_n_o}, 32'd0);
    res_ni = 1'b0;
    #1;
    check("mid_rst_ctl", {27'd0, sram_ce_n_o, sram_oe_n_o, sram_we_n_o, sram_ub_n_o, sram_lb_n_o}, 32'h1F);
    check("mid_rst_dq_oe", {31'd0, sram_dq_oe_o}, 32'd0);
    check("mid_rst_ack", {31'd0, ack_o}, 32'd0);
    ref_dat = 16'h0000;
    cyc_i = 1'b0;
    idle_cycles(1);
    res_ni = 1'b1;
    idle_cycles(1);
    check("rst_abandon_mem", {16'd0, sram_mem[15'h0050]}, {16'd0, ref_mem[15'h0050]});
    do_access(15'h0050, 1'b0, 2'b11, 16'h0000, 1'b0);

    do_access(15'h7FF8, 1'b1, 2'b11, 16'hDEAD, 1'b0);
    do_access(15'h7FF8, 1'b0, 2'b11, 16'h0000, 1'b0);
    do_access(15'h0100, 1'b1, 2'b11, 16'hDEAD, 1'b0);
    do_access(15'h0100, 1'b0, 2'b11, 16'h0000, 1'b0);
    check("unprot_write", {16'd0, dat_o}, 32'h0000DEAD);

    for (int n = 0; n < 300; n++) begin
      a = 15'($urandom_range(0, 31));
      if ($urandom_range(0, 3) == 0) a = a | 15'h7C00;
      do_access(a, 1'($urandom), ($urandom_range(0, 7) == 0) ? 2'b00 : 2'($urandom_range(1, 3)),
                16'($urandom), ($urandom_range(0, 9) == 0));
      if ($urandom_range(0, 1) == 1) idle_cycles($urandom_range(1, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
